// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one SRAM-like port between inst fetch and data requesters
// Optional ARB_ROUND_ROBIN_EN: alternate grants when both requesters are pending.
module sram_req_arbiter #(
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0]       PTR_LAST = 2'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [3:0]       r_id_fifo;
  logic             r_lock;
  logic             r_lock_id;
`ifdef ARB_ROUND_ROBIN_EN
  logic             r_rr_last;
`endif

  logic w_full;
  logic w_sel_valid;
  logic w_sel_id;
  logic w_sel_req;
  logic w_push;
  logic w_pop;
  logic w_head_id;

  assign w_full = (r_cnt == CNT_FULL);

  // Locked requester keeps the port until the slave accepts; otherwise arbitrate.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = 1'b0;
    if (reset) begin
      w_sel_valid = 1'b0;
    end else if (r_lock) begin
      w_sel_valid = 1'b1;
      w_sel_id    = r_lock_id;
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (inst_req && data_req) begin
        w_sel_valid = 1'b1;
        w_sel_id    = ~r_rr_last;
      end else if (data_req) begin
        w_sel_valid = 1'b1;
        w_sel_id    = 1'b1;
      end else if (inst_req) begin
        w_sel_valid = 1'b1;
        w_sel_id    = 1'b0;
      end
`else
      if (data_req) begin
        w_sel_valid = 1'b1;
        w_sel_id    = 1'b1;
      end else if (inst_req) begin
        w_sel_valid = 1'b1;
        w_sel_id    = 1'b0;
      end
`endif
    end
  end

  assign w_sel_req = w_sel_valid & (w_sel_id ? data_req : inst_req);
  assign mem_req   = w_sel_req & ~w_full;

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = 32'd0;
    mem_wstrb = 4'd0;
    mem_wdata = 32'd0;
    if (w_sel_valid) begin
      if (w_sel_id) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wstrb = data_wstrb;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wstrb = inst_wstrb;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign w_push    = mem_req & mem_addr_ok;
  assign w_pop     = mem_data_ok & (r_cnt != '0);
  assign w_head_id = r_id_fifo[r_rd_ptr];

  assign inst_addr_ok = w_push & ~w_sel_id;
  assign data_addr_ok = w_push &  w_sel_id;
  assign inst_data_ok = w_pop  & ~w_head_id;
  assign data_data_ok = w_pop  &  w_head_id;

  // Response data is broadcast; each consumer qualifies it with its own data_ok.
  assign inst_rdata = reset ? 32'd0 : mem_rdata;
  assign data_rdata = reset ? 32'd0 : mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_wr_ptr  <= 2'd0;
      r_rd_ptr  <= 2'd0;
      r_id_fifo <= 4'd0;
    end else begin
      if (w_push) begin
        r_id_fifo[r_wr_ptr] <= w_sel_id;
        r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? 2'd0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? 2'd0 : r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock    <= 1'b0;
      r_lock_id <= 1'b0;
    end else if (w_push) begin
      r_lock    <= 1'b0;
    end else if (mem_req && !mem_addr_ok) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_sel_id;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_last <= 1'b0;
    end else if (w_push) begin
      r_rr_last <= w_sel_id;
    end
  end
`endif

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - directed self-checking bench for sram_req_arbiter
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sram_req_arbiter #(.MAX_OUT(2), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic chk_ok(input string tag, input logic ia, input logic da, input logic id, input logic dd);
    #1;
    check({tag, ".inst_addr_ok"}, 32'(inst_addr_ok), 32'(ia));
    check({tag, ".data_addr_ok"}, 32'(data_addr_ok), 32'(da));
    check({tag, ".inst_data_ok"}, 32'(inst_data_ok), 32'(id));
    check({tag, ".data_data_ok"}, 32'(data_data_ok), 32'(dd));
  endtask

  initial begin
    idle();
    reset = 1;
    inst_req = 1; inst_addr = 32'h1C000000;
    repeat (2) @(posedge clk);
    #1;
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.mem_addr", mem_addr, 0);
    chk_ok("rst", 0, 0, 0, 0);
    @(negedge clk);
    idle();
    reset = 0;
    cyc();

    // single fetch
    inst_req = 1; inst_addr = 32'h1C000000; mem_addr_ok = 1;
    #1;
    check("t1.mem_req", 32'(mem_req), 1);
    check("t1.mem_addr", mem_addr, 32'h1C000000);
    chk_ok("t1.c0", 1, 0, 0, 0);
    cyc(); idle();
    chk_ok("t1.c1", 0, 0, 0, 0);
    cyc(); mem_data_ok = 1; mem_rdata = 32'h02800C0C;
    chk_ok("t1.c2", 0, 0, 1, 0);
    check("t1.inst_rdata", inst_rdata, 32'h02800C0C);
    cyc();
    chk_ok("t1.stray", 0, 0, 0, 0);
    cyc(); idle();

    // contention
    inst_req = 1; inst_addr = 32'h1C000004; data_req = 1; data_addr = 32'h1C008000; mem_addr_ok = 1;
    #1;
    check("t2.mem_addr", mem_addr, 32'h1C008000);
    chk_ok("t2.c0", 0, 1, 0, 0);
    cyc();
`ifdef ARB_ROUND_ROBIN_EN
    check("t2.c1.mem_addr", mem_addr, 32'h1C000004);
    chk_ok("t2.c1", 1, 0, 0, 0);
`else
    check("t2.c1.mem_addr", mem_addr, 32'h1C008000);
    chk_ok("t2.c1", 0, 1, 0, 0);
`endif
    cyc(); idle(); mem_data_ok = 1;
    chk_ok("t2.r0", 0, 0, 0, 1);
    cyc();
`ifdef ARB_ROUND_ROBIN_EN
    chk_ok("t2.r1", 0, 0, 1, 0);
`else
    chk_ok("t2.r1", 0, 0, 0, 1);
`endif
    cyc(); idle();

    // lock on data while slave stalls
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h1C008010; data_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin inst_req = 1; inst_addr = 32'h1C000010; end
      #1;
      check("t3.mem_addr", mem_addr, 32'h1C008010);
      check("t3.mem_wdata", mem_wdata, 32'hDEADBEEF);
      check("t3.mem_wr", 32'(mem_wr), 1);
      chk_ok("t3.stall", 0, 0, 0, 0);
      cyc();
    end
    mem_addr_ok = 1;
    chk_ok("t3.acc", 0, 1, 0, 0);
    cyc(); data_req = 0; data_wr = 0;
    #1;
    check("t3.inst_addr", mem_addr, 32'h1C000010);
    chk_ok("t3.inst", 1, 0, 0, 0);
    cyc(); idle(); mem_data_ok = 1;
    chk_ok("t3.r0", 0, 0, 0, 1);
    cyc();
    chk_ok("t3.r1", 0, 0, 1, 0);
    cyc(); idle();

    // lock on inst holds off the higher-priority data requester
    inst_req = 1; inst_addr = 32'h1C000020;
    chk_ok("t3b.c0", 0, 0, 0, 0);
    cyc(); data_req = 1; data_addr = 32'h1C008020;
    #1;
    check("t3b.mem_addr", mem_addr, 32'h1C000020);
    chk_ok("t3b.c1", 0, 0, 0, 0);
    cyc(); mem_addr_ok = 1;
    chk_ok("t3b.acc", 1, 0, 0, 0);
    cyc(); inst_req = 0;
    chk_ok("t3b.data", 0, 1, 0, 0);
    cyc(); idle(); mem_data_ok = 1;
    chk_ok("t3b.r0", 0, 0, 1, 0);
    cyc();
    chk_ok("t3b.r1", 0, 0, 0, 1);
    cyc(); idle();

    // full
    inst_req = 1; inst_addr = 32'h1C000030; mem_addr_ok = 1;
    chk_ok("t4.a", 1, 0, 0, 0);
    cyc(); inst_req = 0; data_req = 1; data_addr = 32'h1C008030;
    chk_ok("t4.b", 0, 1, 0, 0);
    cyc(); data_req = 0; inst_req = 1; inst_addr = 32'h1C000034;
    #1;
    check("t4.full.mem_req", 32'(mem_req), 0);
    chk_ok("t4.full", 0, 0, 0, 0);
    cyc(); mem_data_ok = 1;
    #1;
    check("t4.popfull.mem_req", 32'(mem_req), 0);
    chk_ok("t4.popfull", 0, 0, 1, 0);
    cyc(); mem_data_ok = 0;
    #1;
    check("t4.regrant.mem_req", 32'(mem_req), 1);
    chk_ok("t4.regrant", 1, 0, 0, 0);
    cyc(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    chk_ok("t4.r1", 0, 0, 0, 1);
    cyc();
    chk_ok("t4.r2", 0, 0, 1, 0);
    cyc(); idle();

    // simultaneous push and pop at cnt=1
    data_req = 1; data_addr = 32'h1C008040; mem_addr_ok = 1;
    chk_ok("t5.push", 0, 1, 0, 0);
    cyc(); data_req = 0; inst_req = 1; inst_addr = 32'h1C000040; mem_data_ok = 1;
    chk_ok("t5.both", 1, 0, 0, 1);
    cyc(); inst_req = 0; mem_addr_ok = 0;
    chk_ok("t5.pop", 0, 0, 1, 0);
    cyc();
    chk_ok("t5.stray", 0, 0, 0, 0);
    cyc(); idle();

    // reset mid-operation with two outstanding
    inst_req = 1; inst_addr = 32'h1C000050; mem_addr_ok = 1;
    chk_ok("t6.p0", 1, 0, 0, 0);
    cyc(); inst_req = 0; data_req = 1; data_addr = 32'h1C008050;
    chk_ok("t6.p1", 0, 1, 0, 0);
    cyc(); reset = 1;
    #1;
    check("t6.rst.mem_req", 32'(mem_req), 0);
    chk_ok("t6.rst", 0, 0, 0, 0);
    cyc(); idle(); reset = 0; mem_data_ok = 1;
    chk_ok("t6.stray0", 0, 0, 0, 0);
    cyc();
    chk_ok("t6.stray1", 0, 0, 0, 0);
    cyc(); mem_data_ok = 0; inst_req = 1; inst_addr = 32'h1C000060; mem_addr_ok = 1;
    #1;
    check("t6.mem_addr", mem_addr, 32'h1C000060);
    chk_ok("t6.grant", 1, 0, 0, 0);
    cyc(); idle(); mem_data_ok = 1; mem_rdata = 32'h12345678;
    chk_ok("t6.resp", 0, 0, 1, 0);
    check("t6.inst_rdata", inst_rdata, 32'h12345678);
    cyc();
    chk_ok("t6.empty", 0, 0, 0, 0);
    cyc(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
